// File: rtl/if_stage_pkg.sv
// ============================================================================
// Module      : if_stage_pkg
// Description : Shared widths, reset PC, bus layouts and the sequential-PC
//               helper used by the instruction-fetch stage and its buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_stage_pkg;

    localparam int          C_XLEN            = 32;
    localparam int          C_FS_TO_DS_BUS_WD = 64;
    localparam int          C_BR_BUS_WD       = 33;
    localparam logic [31:0] C_PC_RESET        = 32'hBFC0_0000;
    // fs_pc sits one word below the boot vector so the first sequential
    // fetch lands exactly on the boot vector.
    localparam logic [31:0] C_FS_PC_RESET     = C_PC_RESET - 32'd4;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } br_bus_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fs_to_ds_bus_t;

    // Sequential successor, 32-bit modulo (0xFFFFFFFC wraps to 0).
    function automatic logic [C_XLEN-1:0] f_seq_pc(input logic [C_XLEN-1:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

`default_nettype wire

// File: rtl/if_inst_buf.sv
// ============================================================================
// Module      : if_inst_buf
// Description : Holds the SRAM read data of the instruction sitting in IF
//               while decode stalls, since the SRAM only presents it for one
//               cycle after the request edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_inst_buf
    import if_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_fs_valid,
    input  logic              i_ds_allowin,
    input  logic [C_XLEN-1:0] i_rdata,
    output logic [C_XLEN-1:0] o_inst
);

    logic              r_buf_valid;
    logic [C_XLEN-1:0] r_buf;
    logic              w_capture;
    logic              w_release;

    // Capture only on the first stalled cycle: that is the one cycle the SRAM
    // data is still fresh. Release needs ds_allowin=1, capture needs it 0,
    // so the two can never coincide.
    assign w_capture = i_fs_valid & ~i_ds_allowin & ~r_buf_valid;
    assign w_release = i_fs_valid &  i_ds_allowin;

    // Buffer register: capture on stall entry, drop once decode takes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf_valid <= 1'b0;
            r_buf       <= '0;
        end else if (w_capture) begin
            r_buf_valid <= 1'b1;
            r_buf       <= i_rdata;
        end else if (w_release) begin
            r_buf_valid <= 1'b0;
        end
    end

    assign o_inst = r_buf_valid ? r_buf : i_rdata;

endmodule

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
// Module      : if_stage
// Description : Instruction-fetch stage. Generates nextpc (sequential, branch
//               redirect, or a redirect deferred past the delay slot), issues
//               the SRAM read and hands {pc, inst} to decode.
//               Optional macro IF_ADDR_ERR_EN adds the fs_adel output and
//               zeroes the instruction of a misaligned fetch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage
    import if_stage_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         ds_allowin,
    input  logic [C_BR_BUS_WD-1:0]       br_bus,
    output logic                         fs_to_ds_valid,
    output logic [C_FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    output logic                         inst_sram_en,
    output logic [3:0]                   inst_sram_we,
    output logic [C_XLEN-1:0]            inst_sram_addr,
    output logic [C_XLEN-1:0]            inst_sram_wdata,
    input  logic [C_XLEN-1:0]            inst_sram_rdata
`ifdef IF_ADDR_ERR_EN
    ,
    output logic                         fs_adel
`endif
);

    br_bus_t           w_br;
    fs_to_ds_bus_t     w_out;
    logic              w_to_fs_valid;
    logic              w_fs_ready_go;
    logic              w_fs_allowin;
    logic              w_to_fs_go;
    logic [C_XLEN-1:0] w_seq_pc;
    logic [C_XLEN-1:0] w_nextpc;
    logic [C_XLEN-1:0] w_buf_inst;
    logic [C_XLEN-1:0] w_fs_inst;

    logic              r_fs_valid;
    logic [C_XLEN-1:0] r_fs_pc;
    logic              r_br_pend;
    logic [C_XLEN-1:0] r_br_pend_target;

    assign w_br = br_bus;

    // Pre-IF handshake: a fetch is requested every cycle IF can accept one.
    assign w_to_fs_valid = ~reset;
    assign w_fs_ready_go = 1'b1;
    assign w_fs_allowin  = ~r_fs_valid | (w_fs_ready_go & ds_allowin);
    assign w_to_fs_go    = w_to_fs_valid & w_fs_allowin;

    assign w_seq_pc = f_seq_pc(r_fs_pc);

    // Next-PC select. A branch seen while IF is empty is not applied now:
    // the delay slot is fetched first and the redirect waits in br_pend.
    always_comb begin
        w_nextpc = w_seq_pc;
        if (r_fs_valid && r_br_pend) begin
            w_nextpc = r_br_pend_target;
        end else if (r_fs_valid && w_br.taken) begin
            w_nextpc = w_br.target;
        end
    end

    // IF valid bit and PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fs_valid <= 1'b0;
            r_fs_pc    <= C_FS_PC_RESET;
        end else if (w_to_fs_go) begin
            r_fs_valid <= 1'b1;
            r_fs_pc    <= w_nextpc;
        end else if (ds_allowin) begin
            r_fs_valid <= 1'b0;
        end
    end

    // Pending redirect: latched once when a branch cannot be applied this
    // cycle, consumed by the next fetch issued with IF holding the delay slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_br_pend        <= 1'b0;
            r_br_pend_target <= '0;
        end else if (w_to_fs_go && r_fs_valid) begin
            r_br_pend <= 1'b0;
        end else if (w_br.taken && !r_br_pend) begin
            r_br_pend        <= 1'b1;
            r_br_pend_target <= w_br.target;
        end
    end

    if_inst_buf u_inst_buf (
        .clk          (clk),
        .rst          (reset),
        .i_fs_valid   (r_fs_valid),
        .i_ds_allowin (ds_allowin),
        .i_rdata      (inst_sram_rdata),
        .o_inst       (w_buf_inst)
    );

`ifdef IF_ADDR_ERR_EN
    assign fs_adel   = r_fs_valid & (r_fs_pc[1:0] != 2'b00);
    assign w_fs_inst = fs_adel ? '0 : w_buf_inst;
`else
    assign w_fs_inst = w_buf_inst;
`endif

    assign w_out.pc       = r_fs_pc;
    assign w_out.inst     = w_fs_inst;
    assign fs_to_ds_bus   = w_out;
    assign fs_to_ds_valid = r_fs_valid & w_fs_ready_go;

    assign inst_sram_en    = w_to_fs_go;
    assign inst_sram_we    = 4'b0000;
    assign inst_sram_addr  = w_nextpc;
    assign inst_sram_wdata = '0;

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
// Module      : tb_if_stage
// Description : Self-checking bench for if_stage. An SRAM model answers each
//               request one cycle later and scribbles garbage when idle;
//               expected {pc, inst} deliveries are queued per scenario and
//               compared whenever decode accepts an instruction.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ds_allowin = 1'b1;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic [32:0] br_bus;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;
`ifdef IF_ADDR_ERR_EN
    logic        fs_adel;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] q[$];
    logic [63:0] m_exp;
    logic [31:0] sram_q;
    int unsigned cyc = 0;

    assign br_bus = {br_taken, br_target};

    if_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ds_allowin      (ds_allowin),
        .br_bus          (br_bus),
        .fs_to_ds_valid  (fs_to_ds_valid),
        .fs_to_ds_bus    (fs_to_ds_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata)
`ifdef IF_ADDR_ERR_EN
        ,
        .fs_adel         (fs_adel)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] f_inst(input logic [31:0] a);
        if (a == 32'hBFC0_0004) return 32'h2401_0001;
        return a ^ 32'h5A5A_A5A5;
    endfunction

    function automatic logic [31:0] f_exp_inst(input logic [31:0] pc);
`ifdef IF_ADDR_ERR_EN
        if (pc[1:0] != 2'b00) return 32'h0;
`endif
        return f_inst(pc);
    endfunction

    // SRAM model: data one cycle after the request edge, garbage when idle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (inst_sram_en) sram_q <= f_inst(inst_sram_addr);
        else              sram_q <= 32'hDEAD_0000 | {16'h0, cyc[15:0]};
    end
    assign inst_sram_rdata = sram_q;

    task automatic tb_check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] pc);
        q.push_back({pc, f_exp_inst(pc)});
    endtask

    // Scoreboard: every instruction decode accepts must match the queue head.
    always @(negedge clk) begin
        if (!reset && fs_to_ds_valid && ds_allowin) begin
            tb_check("deliver_expected", 64'(q.size() != 0), 64'd1);
            if (q.size() != 0) begin
                m_exp = q.pop_front();
                tb_check("deliver", fs_to_ds_bus, m_exp);
`ifdef IF_ADDR_ERR_EN
                tb_check("adel", 64'(fs_adel), 64'(m_exp[33:32] != 2'b00));
`endif
            end
        end
    end

    // Leaves reset asserted at a #1 point; caller deasserts it (cycle 0).
    task automatic do_reset();
        reset = 1'b1;
        ds_allowin = 1'b1;
        br_taken = 1'b0;
        br_target = 32'h0;
        step();
        step();
        @(negedge clk);
        tb_check("rst_en",    64'(inst_sram_en), 64'd0);
        tb_check("rst_valid", 64'(fs_to_ds_valid), 64'd0);
        tb_check("rst_addr",  64'(inst_sram_addr), 64'hBFC0_0000);
        tb_check("rst_pc",    64'(fs_to_ds_bus[63:32]), 64'hBFBF_FFFC);
        tb_check("tie_we",    64'(inst_sram_we), 64'd0);
        tb_check("tie_wdata", 64'(inst_sram_wdata), 64'd0);
        q.delete();
        step();
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            if (q.size() == 0) begin
                ds_allowin = 1'b0;
                step();
                step();
                return;
            end
            step();
        end
        tb_check("drain_timeout", 64'(q.size()), 64'd0);
        q.delete();
    endtask

    task automatic chk_addr(input string tag, input logic [31:0] exp);
        @(negedge clk);
        tb_check(tag, 64'(inst_sram_addr), 64'(exp));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Stall while fs_pc=0xBFC00004; SRAM corrupts after the request cycle.
        do_reset();
        push(32'hBFC0_0000); push(32'hBFC0_0004); push(32'hBFC0_0008); push(32'hBFC0_000C);
        reset = 1'b0;                       // cycle 0
        step();                             // cycle 1
        step(); ds_allowin = 1'b0;          // cycle 2
        step();                             // cycle 3
        @(negedge clk);
        tb_check("stall_bus3", fs_to_ds_bus, {32'hBFC0_0004, 32'h2401_0001});
        tb_check("stall_en3",  64'(inst_sram_en), 64'd0);
        step();                             // cycle 4
        @(negedge clk);
        tb_check("stall_bus4", fs_to_ds_bus, {32'hBFC0_0004, 32'h2401_0001});
        step(); ds_allowin = 1'b1;          // cycle 5: single delivery
        drain();

        // Branch with IF valid: redirect applied immediately.
        do_reset();
        push(32'hBFC0_0000); push(32'hBFC0_0004); push(32'hBFC0_0100); push(32'hBFC0_0104);
        reset = 1'b0;
        step();
        step(); br_taken = 1'b1; br_target = 32'hBFC0_0100;
        chk_addr("br_now", 32'hBFC0_0100);
        step(); br_taken = 1'b0;
        chk_addr("br_now_next", 32'hBFC0_0104);
        step();
        drain();

        // Branch with IF empty: delay slot first, then target, then pend clears.
        do_reset();
        push(32'hBFC0_0000); push(32'hBFC0_0100); push(32'hBFC0_0104);
        reset = 1'b0; br_taken = 1'b1; br_target = 32'hBFC0_0100;
        chk_addr("ds_slot", 32'hBFC0_0000);
        step(); br_taken = 1'b0;
        chk_addr("ds_target", 32'hBFC0_0100);
        step();
        chk_addr("ds_cleared", 32'hBFC0_0104);
        step();
        drain();

        // Branch held two stalled cycles: only the first target is taken.
        do_reset();
        push(32'hBFC0_0000); push(32'hBFC0_0004); push(32'hBFC0_0100); push(32'hBFC0_0104);
        reset = 1'b0;
        step();
        step(); ds_allowin = 1'b0; br_taken = 1'b1; br_target = 32'hBFC0_0100;
        step(); br_target = 32'hBFC0_0200;
        chk_addr("hold_pend", 32'hBFC0_0100);
        step(); br_taken = 1'b0; ds_allowin = 1'b1;
        @(negedge clk);
        tb_check("hold_en", 64'(inst_sram_en), 64'd1);
        tb_check("hold_addr", 64'(inst_sram_addr), 64'hBFC0_0100);
        step();
        chk_addr("hold_after", 32'hBFC0_0104);
        step();
        drain();

        // Reset while stalled with a pending branch and a buffered instruction.
        do_reset();
        push(32'hBFC0_0000);
        reset = 1'b0;
        step();
        step(); ds_allowin = 1'b0; br_taken = 1'b1; br_target = 32'hBFC0_0300;
        step(); br_taken = 1'b0;
        step();
        tb_check("mid_reset_q", 64'(q.size()), 64'd0);

        // Fresh boot sequence; must show no leftover pend/buffer state.
        do_reset();
        push(32'hBFC0_0000); push(32'hBFC0_0004); push(32'hBFC0_0008); push(32'hBFC0_000C);
        reset = 1'b0;
        @(negedge clk);
        tb_check("boot_en", 64'(inst_sram_en), 64'd1);
        tb_check("boot_addr0", 64'(inst_sram_addr), 64'hBFC0_0000);
        step();
        chk_addr("boot_addr1", 32'hBFC0_0004);
        step();
        chk_addr("boot_addr2", 32'hBFC0_0008);
        step();
        drain();

        // Misaligned branch target.
        do_reset();
        push(32'hBFC0_0000); push(32'hBFC0_0004); push(32'hBFC0_0102); push(32'hBFC0_0106);
        reset = 1'b0;
        step();
        step(); br_taken = 1'b1; br_target = 32'hBFC0_0102;
        chk_addr("mis_addr", 32'hBFC0_0102);
        step(); br_taken = 1'b0;
        step();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 ds_allowin  input  1  decode stage can accept an instruction this cycle.
REQ-004 br_bus  input  `BR_BUS_WD (33)  {br_taken, br_target[31:0]} from decode; br_target is already the final redirect address.
REQ-005 fs_to_ds_valid  output  1  fetch stage holds a valid instruction for decode.
REQ-006 fs_to_ds_bus  output  `FS_TO_DS_BUS_WD (64)  {fs_pc[31:0], fs_inst[31:0]}.
REQ-007 inst_sram_en  output  1  instruction SRAM read request.
REQ-008 inst_sram_we  output  4  tied 4'b0.
REQ-009 inst_sram_addr  output  32  equals nextpc.
REQ-010 inst_sram_wdata  output  32  tied 32'b0.
REQ-011 inst_sram_rdata  input  32  read data, valid exactly one cycle after the request edge.

Function
REQ-012 Pre-IF: to_fs_valid = ~reset; transfer pre-IF->IF when to_fs_valid && fs_allowin; inst_sram_en = that transfer condition.
REQ-013 fs_ready_go = 1; fs_allowin = ~fs_valid || ds_allowin; fs_to_ds_valid = fs_valid.
REQ-014 On transfer: fs_valid <= 1, fs_pc <= nextpc; else if ds_allowin: fs_valid <= 0; otherwise hold.
REQ-015 seq_pc = fs_pc + 4, 32-bit modulo; 0xFFFFFFFC wraps to 0x00000000.
REQ-016 nextpc priority: (fs_valid && br_pend) -> br_pend_target; else (fs_valid && br_taken) -> br_target; else seq_pc.
REQ-017 Delay slot: with fs_valid=0, a taken branch is not applied; the next fetch is seq_pc (the delay slot).
REQ-018 br_pend <= 1, br_pend_target <= br_target when br_taken && ~br_pend && ~(transfer && fs_valid).
REQ-019 br_pend clears on a transfer with fs_valid=1; br_taken is ignored while br_pend=1.
REQ-020 Instruction buffer: capture inst_sram_rdata into inst_buf and set inst_buf_valid on the first cycle where fs_valid && ~ds_allowin && ~inst_buf_valid.
REQ-021 fs_inst = inst_buf_valid ? inst_buf : inst_sram_rdata.
REQ-022 inst_buf_valid clears when fs_valid && ds_allowin. Capture and clear in the same cycle is impossible by construction.
REQ-023 A stall of any length delivers the same instruction to decode exactly once, with no duplicate and no drop.

Reset
REQ-024 During reset: fs_valid=0, br_pend=0, br_pend_target=0, inst_buf_valid=0, inst_buf=0, inst_sram_en=0.
REQ-025 fs_pc resets to 0xBFBFFFFC, so the first fetch after reset deasserts is 0xBFC00000 (`PC_RESET).
REQ-026 Reset asserted mid-stall or mid-pending discards all buffered and pending state; no fetch is issued while reset=1.

Configuration
REQ-027 Macro IF_ADDR_ERR_EN.
- Defined: extra output fs_adel (1 bit) = fs_valid && fs_pc[1:0]!=0; fs_inst forced to 32'b0 when fs_adel=1.
- Undefined: port absent; no alignment check; fs_inst per REQ-021.

Structure
REQ-028 cpu.vh holds `XLEN, `FS_TO_DS_BUS_WD=64, `BR_BUS_WD=33 and `PC_RESET=32'hBFC00000, shared with id_stage.
REQ-029 The buffer (REQ-020..022) is one sub-module, if_inst_buf; PC, valid and pending logic stay in if_stage.

Verification
REQ-030 Release reset with ds_allowin=1 -> addr 0xBFC00000, 0xBFC00004, 0xBFC00008 on consecutive cycles; fs_pc follows one cycle later.
REQ-031 Stall: ds_allowin=0 for 3 cycles while fs_pc=0xBFC00004, SRAM returns 0x24010001 and is then corrupted -> fs_to_ds_bus holds {0xBFC00004, 0x24010001}; issued once after release.
REQ-032 br_taken=1, target 0xBFC00100, fs_valid=1, ds_allowin=1 -> next addr 0xBFC00100.
REQ-033 br_taken=1 with fs_valid=0 -> delay slot fs_pc+4 fetched first, then 0xBFC00100; br_pend clears.
REQ-034 br_taken held 2 cycles with ds_allowin=0 -> single redirect to target, no double apply.
REQ-035 IF_ADDR_ERR_EN, br_target=0xBFC00102 -> fs_adel=1 and fs_inst=0 for that instruction.
